// File: rtl/urv_mem_arb.sv
// urv_mem_arb: N-to-1 memory-port arbiter with registered master request and in-order response steering.
// Define URV_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority; the default build is round-robin.

package urv_mem_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } mem_resp_t;

endpackage

module urv_mem_arb
    import urv_mem_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      s_req_valid,
    output logic [NUM_REQ-1:0]      s_req_ready,
    input  mem_req_t [NUM_REQ-1:0]  s_req,
    output logic [NUM_REQ-1:0]      s_resp_valid,
    output mem_resp_t               s_resp,
    output logic                    m_req_valid,
    input  logic                    m_req_ready,
    output mem_req_t                m_req,
    input  logic                    m_resp_valid,
    input  mem_resp_t               m_resp,
    output logic                    err_unexp
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUTS_DEPTH + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_after_pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ID_W-1:0]  tag_mem [OUTS_DEPTH];
    logic [ID_W-1:0]  win;
    logic             slot_free;
    logic             pop;
    logic             capture;

    // Pointers wrap at OUTS_DEPTH explicitly so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign slot_free     = !m_req_valid || m_req_ready;
    assign pop           = !rst && m_resp_valid && (cnt != '0);
    assign cnt_after_pop = cnt - CNT_W'(pop);
    assign capture       = !rst && slot_free && (cnt_after_pop < CNT_W'(OUTS_DEPTH)) && (|s_req_valid);

`ifdef URV_MEM_ARB_FIXED_PRIO_EN

    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (s_req_valid[i]) win = ID_W'(i);
        end
    end

`else

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_idx;
    logic            found;

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        win    = '0;
        rr_idx = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && s_req_valid[rr_idx]) begin
                win   = rr_idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          rr_ptr <= ID_W'(NUM_REQ - 1);
        else if (capture) rr_ptr <= win;
    end

`endif

    always_comb begin
        s_req_ready = '0;
        if (capture) s_req_ready[win] = 1'b1;
    end

    // A response is steered to the oldest outstanding requester, even if its request is still held.
    always_comb begin
        s_resp_valid = '0;
        if (pop) s_resp_valid[tag_mem[rd_ptr]] = 1'b1;
    end

    assign s_resp = m_resp;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_req_valid <= 1'b0;
            m_req       <= '0;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            err_unexp   <= 1'b0;
        end else begin
            if (capture) begin
                m_req_valid <= 1'b1;
                m_req       <= s_req[win];
            end else if (m_req_ready) begin
                m_req_valid <= 1'b0;
            end
            if (capture) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            cnt <= cnt_after_pop + CNT_W'(capture);
            if (m_resp_valid && (cnt == '0)) err_unexp <= 1'b1;
        end
    end

    // NOTE: the tag storage is not reset; entries are only read between push and pop, guarded by cnt.
    always_ff @(posedge clk) begin
        if (capture) tag_mem[wr_ptr] <= win;
    end

endmodule
